div_arbiter: RTL and testbench

Round-robin arbiter that shares one repeated-subtraction divider (16-bit dividend, 8-bit divisor, INI/OCUP/P/R/REM handshake) among NREQ requesters. It accepts a request, drives the divider's INI/A/B, waits for the divider's completion pulse, then returns quotient and remainder to the granted requester with a one-cycle done strobe. It rejects divide-by-zero without launching the divider, because a zero divisor never terminates the divider's subtract loop. It sits between requester blocks and the single divider instance, and is the divider's only driver.

---
 rtl/div_arbiter_if.sv | 29 ++
 rtl/div_arbiter.sv | 73 +++++++
 tb/tb_div_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester and divider signals of the shared-divider arbiter
interface div_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     done;
    logic [15:0]         res_q;
    logic [7:0]          res_rem;
    logic                res_err;
    logic                busy;
    logic                div_ini;
    logic [15:0]         div_a;
    logic [7:0]          div_b;
    logic                div_ocup;
    logic                div_p;
    logic [15:0]         div_r;
    logic [7:0]          div_rem;
    modport master (
        input  req, req_a, req_b, div_ocup, div_p, div_r, div_rem,
        output ack, done, res_q, res_rem, res_err, busy, div_ini, div_a, div_b
    );
    modport slave (
        output req, req_a, req_b, div_ocup, div_p, div_r, div_rem,
        input  ack, done, res_q, res_rem, res_err, busy, div_ini, div_a, div_b
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one repeated-subtraction divider among NREQ requesters
module div_arbiter #(
    parameter int NREQ = 4
) (
    input logic           clk,
    input logic           reset,
    div_arbiter_if.master bus
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RESP} state_t;
    state_t        state;
    logic [IW-1:0] ptr, idx, win;
    logic [15:0]   a_w;
    logic [7:0]    b_w;
    always_comb begin
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[(int'(ptr) + k) % NREQ]) win = IW'((int'(ptr) + k) % NREQ);
    end
    assign a_w = bus.req_a[16*int'(win) +: 16];
    assign b_w = bus.req_b[8*int'(win) +: 8];
    // start is decoded from div_ocup so a stall releases in the very cycle the divider frees up
    assign bus.div_ini = state == LAUNCH && !bus.div_ocup;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            bus.ack     <= '0;
            bus.done    <= '0;
            bus.res_q   <= '0;
            bus.res_rem <= '0;
            bus.res_err <= 1'b0;
            bus.busy    <= 1'b0;
            bus.div_a   <= '0;
            bus.div_b   <= '0;
        end else begin
            bus.ack  <= '0;
            bus.done <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    idx       <= win;
                    bus.div_a <= a_w;
                    bus.div_b <= b_w;
                    bus.ack   <= NREQ'(1) << win;
                    bus.busy  <= 1'b1;
                    if (b_w == '0) begin
                        bus.done    <= NREQ'(1) << win;
                        bus.res_q   <= 16'hFFFF;
                        bus.res_rem <= a_w[7:0];
                        bus.res_err <= 1'b1;
                        state       <= RESP;
                    end else state <= LAUNCH;
                end
                LAUNCH: if (!bus.div_ocup) state <= WAIT;
                WAIT: if (bus.div_p) state <= CAPTURE;
                CAPTURE: begin
                    bus.done    <= NREQ'(1) << idx;
                    bus.res_q   <= bus.div_r;
                    bus.res_rem <= bus.div_rem;
                    bus.res_err <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    ptr      <= idx == IW'(NREQ - 1) ? '0 : idx + 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed and random checks of div_arbiter against a behavioural divider and arbitration model
module tb_div_arbiter;
    localparam int N = 4;
    typedef struct {
        int          idx;
        int          cyc;
        logic [15:0] q;
        logic [7:0]  rem;
        logic        err;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if #(.NREQ(N)) bus ();
    div_arbiter #(.NREQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_until = 0;
    int   busy_cnt = 0;
    int   ini_cnt = 0;
    int   mptr = 0;
    ev_t  ack_q[$];
    ev_t  done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // divider: LOAD, COMP, q x (CALC, COMP), OUTPUT; results appear the cycle after the pulse
    int          ph = 0;
    int          cnt = 0;
    logic [15:0] dq;
    logic [7:0]  dr;
    logic        m_ocup = 1'b0;
    assign bus.div_ocup = m_ocup | (cyc < stall_until);
    always @(posedge clk) begin
        if (!reset) begin
            ph <= 0; cnt <= 0; m_ocup <= 1'b0;
            bus.div_p <= 1'b0; bus.div_r <= '0; bus.div_rem <= '0;
        end else if (ph == 0) begin
            if (bus.div_ini) begin
                dq     <= bus.div_a / 16'(bus.div_b);
                dr     <= 8'(bus.div_a % 16'(bus.div_b));
                cnt    <= 2 * int'(bus.div_a / 16'(bus.div_b)) + 2;
                m_ocup <= 1'b1;
                ph     <= 1;
            end
        end else if (ph == 1) begin
            if (cnt > 1) cnt <= cnt - 1;
            else begin bus.div_p <= 1'b1; ph <= 2; end
        end else begin
            bus.div_p <= 1'b0; bus.div_r <= dq; bus.div_rem <= dr; m_ocup <= 1'b0; ph <= 0;
        end
    end

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < N; k++) begin
            if (bus.ack[k] === 1'b1) ack_q.push_back('{idx: k, cyc: cyc, q: 16'd0, rem: 8'd0, err: 1'b0});
            if (bus.done[k] === 1'b1) done_q.push_back('{idx: k, cyc: cyc, q: bus.res_q, rem: bus.res_rem, err: bus.res_err});
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.div_ini === 1'b1) ini_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_res_q"}, 32'(bus.res_q), 0);
        chk({tag, "_res_rem"}, 32'(bus.res_rem), 0);
        chk({tag, "_res_err"}, 32'(bus.res_err), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_div_ini"}, 32'(bus.div_ini), 0);
        chk({tag, "_div_a"}, 32'(bus.div_a), 0);
        chk({tag, "_div_b"}, 32'(bus.div_b), 0);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_ev(input string tag, input bit want_done, input int base);
        for (int n = 0; n < 2000 && (want_done ? done_q.size() : ack_q.size()) <= base; n++) @(negedge clk);
        if ((want_done ? done_q.size() : ack_q.size()) <= base) begin
            $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
            $fatal(1, "FAIL %s timeout observed=none expected=event", tag);
        end
    endtask

    task automatic single(input string tag, input int i, input logic [15:0] a, input logic [7:0] b, input int s);
        int g, lat, a0, d0, b0, n0;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ee;
        ee  = b == 8'd0;
        eq  = ee ? 16'hFFFF : a / 16'(b);
        er  = ee ? a[7:0] : 8'(a % 16'(b));
        lat = ee ? 1 : 6 + 2 * int'(eq) + (s > 0 ? s - 1 : 0);
        a0 = ack_q.size(); d0 = done_q.size(); b0 = busy_cnt; n0 = ini_cnt;
        g = cyc;
        stall_until = g + s;
        bus.req_a[16*i +: 16] = a;
        bus.req_b[8*i +: 8]   = b;
        bus.req[i]            = 1'b1;
        for (int n = 0; n < 1500 && done_q.size() == d0; n++) begin
            @(negedge clk);
            if (ack_q.size() > a0) bus.req[i] = 1'b0;
        end
        wait_ev({tag, "_done"}, 1'b1, d0);
        chk({tag, "_nack"}, 32'(ack_q.size() - a0), 1);
        chk({tag, "_ack_idx"}, 32'(ack_q[a0].idx), 32'(i));
        chk({tag, "_ack_cyc"}, 32'(ack_q[a0].cyc - g), 1);
        chk({tag, "_done_idx"}, 32'(done_q[d0].idx), 32'(i));
        chk({tag, "_latency"}, 32'(done_q[d0].cyc - g), 32'(lat));
        chk({tag, "_res_q"}, 32'(done_q[d0].q), 32'(eq));
        chk({tag, "_res_rem"}, 32'(done_q[d0].rem), 32'(er));
        chk({tag, "_res_err"}, 32'(done_q[d0].err), 32'(ee));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(lat));
        chk({tag, "_ini_count"}, 32'(ini_cnt - n0), ee ? 0 : 1);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
        mptr = (i + 1) % N;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mptr = 0;
        @(negedge clk);
    endtask

    logic [15:0] ra;
    logic [7:0]  rb;
    int          ri, e, prev, ai, di, d0;

    initial begin
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        single("q14", 0, 16'd100, 8'd7, 0);
        single("a_lt_b", 3, 16'd5, 8'd9, 0);
        single("div0", 1, 16'h1234, 8'd0, 0);
        single("stall", 2, 16'd50, 8'd10, 4);
        single("max", 3, 16'hFFFF, 8'd255, 0);
        for (int r = 0; r < 10; r++) begin
            ri = int'($urandom_range(0, N - 1));
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ra = (rb == 8'd0) ? 16'($urandom) : 16'($urandom_range(0, 151 * int'(rb) - 1));
            single("rand", ri, ra, rb, int'($urandom_range(0, 2)));
        end

        // reset while the divider is deep in a long 200/1 run
        d0 = done_q.size();
        ai = ack_q.size();
        bus.req_a[15:0] = 16'd200; bus.req_b[7:0] = 8'd1; bus.req[0] = 1'b1;
        wait_ev("midwait_ack", 1'b0, ai);
        bus.req[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("midwait_busy", 32'(bus.busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        reset = 1'b1;
        mptr = 0;
        repeat (450) @(negedge clk);
        chk("midreset_no_done", 32'(done_q.size() - d0), 0);
        single("fresh", 0, 16'd9, 8'd3, 0);

        do_reset();
        bus.req_a = {N{16'd20}};
        bus.req_b = {N{8'd10}};
        bus.req = '1;
        ai = ack_q.size();
        di = done_q.size();
        prev = 0;
        for (int g = 0; g < 8; g++) begin
            e = pick(bus.req, mptr);
            wait_ev("rr_ack", 1'b0, ai);
            chk("rr_ack_idx", 32'(ack_q[ai].idx), 32'(e));
            if (g > 0) chk("rr_spacing", 32'(ack_q[ai].cyc - prev), 11);
            prev = ack_q[ai].cyc;
            ai++;
            wait_ev("rr_done", 1'b1, di);
            chk("rr_done_idx", 32'(done_q[di].idx), 32'(e));
            chk("rr_done_after_ack", 32'(done_q[di].cyc - prev), 9);
            chk("rr_res_q", 32'(done_q[di].q), 2);
            chk("rr_res_rem", 32'(done_q[di].rem), 0);
            di++;
            mptr = (e + 1) % N;
            if (g == 3) bus.req = 4'b0101;
            if (g == 7) bus.req = '0;
        end
        repeat (3) @(negedge clk);
        chk("rr_idle", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
